// File: rtl/text_overlay_pkg.sv
// Shared glyph codes, default cell geometry and FSM state type for the text overlay.
package text_overlay_pkg;

    localparam logic [4:0] GLYPH_S     = 5'd0;
    localparam logic [4:0] GLYPH_T     = 5'd1;
    localparam logic [4:0] GLYPH_R     = 5'd2;
    localparam logic [4:0] GLYPH_G     = 5'd3;
    localparam logic [4:0] GLYPH_A     = 5'd4;
    localparam logic [4:0] GLYPH_M     = 5'd5;
    localparam logic [4:0] GLYPH_H     = 5'd6;
    localparam logic [4:0] GLYPH_I     = 5'd7;
    localparam logic [4:0] GLYPH_O     = 5'd8;
    localparam logic [4:0] GLYPH_V     = 5'd9;
    localparam logic [4:0] GLYPH_BLANK = 5'd31;

    localparam int unsigned DEF_CHAR_W = 10;
    localparam int unsigned DEF_CHAR_H = 20;
    localparam int unsigned DEF_PITCH  = 12;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StClear
    } state_e;

endpackage

// File: rtl/text_overlay_if.sv
// Write channel, scan position and renderer outputs of the text overlay.
interface text_overlay_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_char;
    logic        wr_last;
    logic        clear;
    logic [9:0]  org_x;
    logic [9:0]  org_y;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blink_en;
    logic        frame_tick;
    logic [4:0]  sel_char;
    logic [31:0] pos_x;
    logic [31:0] pos_y;
    logic        cell_active;
    logic [4:0]  disp_len;

    modport master (
        output wr_valid, wr_char, wr_last, clear, org_x, org_y, x, y, blink_en, frame_tick,
        input  wr_ready, sel_char, pos_x, pos_y, cell_active, disp_len
    );

    modport slave (
        input  wr_valid, wr_char, wr_last, clear, org_x, org_y, x, y, blink_en, frame_tick,
        output wr_ready, sel_char, pos_x, pos_y, cell_active, disp_len
    );
endinterface

// File: rtl/text_buffer.sv
// Character string storage: one synchronous write port, one combinational read port.
module text_buffer
    import text_overlay_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned AW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [4:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [4:0]    rdata_o
);

    logic [4:0] mem_q [MAX_CHARS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MAX_CHARS); i++) mem_q[i] <= GLYPH_BLANK;
        end else if (we_i && (32'(waddr_i) < MAX_CHARS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = GLYPH_BLANK;
        if (32'(raddr_i) < MAX_CHARS) rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/text_overlay.sv
// Text string overlay: loads a glyph string, maps scan pixels to glyph cells, blinks per frame.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned CHAR_W    = DEF_CHAR_W,
    parameter int unsigned CHAR_H    = DEF_CHAR_H,
    parameter int unsigned PITCH     = DEF_PITCH,
    parameter int unsigned BLINK_DIV = 32
) (
    input logic           clk,
    input logic           reset,
    text_overlay_if.slave ovl
);

    localparam int unsigned AW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int unsigned IW = $clog2(MAX_CHARS + 1);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   widx_q, widx_d;
    logic [4:0]      len_q, len_d;
    logic            xfer;
    logic            buf_we;
    logic [AW-1:0]   buf_waddr;
    logic [4:0]      buf_wdata;
    logic [AW-1:0]   buf_raddr;
    logic [4:0]      buf_rdata;

    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            vis_q, vis_d;

    logic [9:0]      dx, cidx, crem;
    logic            in_x, in_y, in_cell;
    logic [4:0]      sel_q, sel_d;
    logic [31:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic            act_q, act_d;

    assign xfer = ovl.wr_valid && ovl.wr_ready;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next state; clear overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (xfer && !ovl.wr_last) state_d = StLoad;
            StLoad:  if (xfer && ovl.wr_last) state_d = StIdle;
            StClear: if (widx_q == IW'(MAX_CHARS - 1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (ovl.clear) state_d = StClear;
    end

    // FSM outputs: buffer write, write index, committed length
    always_comb begin
        ovl.wr_ready = (state_q != StClear);
        widx_d       = widx_q;
        len_d        = len_q;
        buf_we       = 1'b0;
        buf_waddr    = widx_q[AW-1:0];
        buf_wdata    = ovl.wr_char;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    widx_d    = IW'(1);
                    if (ovl.wr_last) len_d = 5'(1);
                end
            end
            StLoad: begin
                if (xfer) begin
                    // Characters past the buffer end are acknowledged but dropped
                    if (widx_q < IW'(MAX_CHARS)) begin
                        buf_we = 1'b1;
                        widx_d = widx_q + IW'(1);
                    end
                    if (ovl.wr_last) len_d = 5'(widx_d);
                end
            end
            StClear: begin
                buf_we    = 1'b1;
                buf_wdata = GLYPH_BLANK;
                widx_d    = (widx_q == IW'(MAX_CHARS - 1)) ? '0 : widx_q + IW'(1);
            end
            default: ;
        endcase
        if (ovl.clear) begin
            buf_we = 1'b0;
            widx_d = '0;
            len_d  = '0;
        end
    end

    text_buffer #(
        .MAX_CHARS (MAX_CHARS),
        .AW        (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        vis_d       = vis_q;
        if (!ovl.blink_en) begin
            blink_cnt_d = '0;
            vis_d       = 1'b1;
        end else if (ovl.frame_tick) begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                vis_d       = ~vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Pixel-to-cell mapping; dx is only meaningful when in_x holds
    always_comb begin
        dx        = ovl.x - ovl.org_x;
        cidx      = dx / 10'(PITCH);
        crem      = dx % 10'(PITCH);
        in_x      = (ovl.x >= ovl.org_x);
        in_y      = ({1'b0, ovl.y} >= {1'b0, ovl.org_y}) &&
                    ({1'b0, ovl.y} <= ({1'b0, ovl.org_y} + 11'(CHAR_H - 1)));
        in_cell   = in_x && in_y && (cidx < {5'b0, len_q}) && (crem < 10'(CHAR_W));
        buf_raddr = cidx[AW-1:0];
        sel_d     = GLYPH_BLANK;
        act_d     = 1'b0;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        if (in_cell && vis_q) begin
            sel_d   = buf_rdata;
            act_d   = 1'b1;
            pos_x_d = 32'(ovl.org_x) + 32'(cidx) * 32'(PITCH);
            pos_y_d = 32'(ovl.org_y);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            widx_q      <= '0;
            len_q       <= '0;
            blink_cnt_q <= '0;
            vis_q       <= 1'b1;
            sel_q       <= GLYPH_BLANK;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            act_q       <= 1'b0;
        end else begin
            widx_q      <= widx_d;
            len_q       <= len_d;
            blink_cnt_q <= blink_cnt_d;
            vis_q       <= vis_d;
            sel_q       <= sel_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            act_q       <= act_d;
        end
    end

    assign ovl.sel_char    = sel_q;
    assign ovl.pos_x       = pos_x_q;
    assign ovl.pos_y       = pos_y_q;
    assign ovl.cell_active = act_q;
    assign ovl.disp_len    = len_q;

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: a reference model predicts each pixel result.
module tb_text_overlay;

    typedef struct {
        logic [31:0] sel;
        logic [31:0] px;
        logic [31:0] py;
        logic [31:0] act;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    text_overlay_if ovl();

    text_overlay dut (
        .clk   (clk),
        .reset (reset),
        .ovl   (ovl)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    int mdl_buf[16];
    int mdl_len, mdl_widx, mdl_cnt, mdl_px, mdl_py;
    bit mdl_vis, mdl_blink_en;
    int org_x = 100;
    int org_y = 50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl_buf[i] = 31;
        mdl_len = 0; mdl_widx = 0; mdl_cnt = 0; mdl_px = 0; mdl_py = 0; mdl_vis = 1;
    endtask

    task automatic send(input int c, input bit last);
        int n = 0;
        ovl.wr_valid = 1'b1;
        ovl.wr_char  = 5'(c);
        ovl.wr_last  = last;
        while (!ovl.wr_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (n == 64) check_eq("wr_ready_timeout", 32'(ovl.wr_ready), 32'd1);
        @(posedge clk); #1;
        ovl.wr_valid = 1'b0;
        ovl.wr_last  = 1'b0;
        if (mdl_widx < 16) begin
            mdl_buf[mdl_widx] = c;
            mdl_widx++;
        end
        if (last) begin
            mdl_len  = mdl_widx;
            mdl_widx = 0;
        end
    endtask

    task automatic pixel(input int px, input int py, input string tag);
        exp_t e;
        int dx, idx;
        bit hit = 0;
        ovl.x = 10'(px);
        ovl.y = 10'(py);
        idx = 0;
        if (px >= org_x && py >= org_y && py <= org_y + 19) begin
            dx  = px - org_x;
            idx = dx / 12;
            hit = (idx < mdl_len) && (dx % 12 < 10);
        end
        if (hit && mdl_vis) begin
            e.sel  = 32'(mdl_buf[idx]);
            e.act  = 1;
            mdl_px = org_x + idx * 12;
            mdl_py = org_y;
        end else begin
            e.sel = 31;
            e.act = 0;
        end
        e.px = 32'(mdl_px);
        e.py = 32'(mdl_py);
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check_eq({tag, ".sel_char"}, 32'(ovl.sel_char), e.sel);
        check_eq({tag, ".cell_active"}, 32'(ovl.cell_active), e.act);
        check_eq({tag, ".pos_x"}, ovl.pos_x, e.px);
        check_eq({tag, ".pos_y"}, ovl.pos_y, e.py);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ovl.frame_tick = 1'b1;
            @(posedge clk); #1;
            ovl.frame_tick = 1'b0;
            if (mdl_blink_en) begin
                mdl_cnt++;
                if (mdl_cnt == 32) begin
                    mdl_cnt = 0;
                    mdl_vis = !mdl_vis;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".sel_char"}, 32'(ovl.sel_char), 32'd31);
        check_eq({tag, ".pos_x"}, ovl.pos_x, 32'd0);
        check_eq({tag, ".pos_y"}, ovl.pos_y, 32'd0);
        check_eq({tag, ".cell_active"}, 32'(ovl.cell_active), 32'd0);
        check_eq({tag, ".disp_len"}, 32'(ovl.disp_len), 32'd0);
        check_eq({tag, ".wr_ready"}, 32'(ovl.wr_ready), 32'd1);
    endtask

    initial begin
        int low;
        reset          = 1'b1;
        ovl.wr_valid   = 1'b0;
        ovl.wr_char    = 5'd0;
        ovl.wr_last    = 1'b0;
        ovl.clear      = 1'b0;
        ovl.org_x      = 10'(org_x);
        ovl.org_y      = 10'(org_y);
        ovl.x          = 10'd0;
        ovl.y          = 10'd0;
        ovl.blink_en   = 1'b0;
        ovl.frame_tick = 1'b0;
        mdl_blink_en   = 0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // S,T,A,R,T
        send(0, 0);
        check_eq("load_holds_len", 32'(ovl.disp_len), 32'd0);
        send(1, 0); send(4, 0); send(2, 0); send(1, 1);
        check_eq("start.disp_len", 32'(ovl.disp_len), 32'd5);
        pixel(124, 60, "cell_a");
        pixel(110, 60, "gap");
        pixel(99, 60, "left_of_org");
        pixel(100, 49, "above");
        pixel(100, 69, "last_row");
        pixel(100, 70, "below");
        pixel(157, 60, "cell4_edge");
        pixel(160, 60, "past_len");

        // 20 characters; the last four must be discarded
        for (int i = 0; i < 20; i++) begin
            send(i % 10, i == 19);
            if (i == 9) check_eq("load20_holds_len", 32'(ovl.disp_len), 32'd5);
        end
        check_eq("long.disp_len", 32'(ovl.disp_len), 32'd16);
        pixel(100, 55, "long_cell0");
        pixel(136, 55, "long_cell3");
        pixel(280, 55, "long_cell15");
        pixel(292, 55, "long_cell16");

        // clear during a load, with a write colliding with the pulse
        send(7, 0); send(8, 0); send(9, 0);
        ovl.clear    = 1'b1;
        ovl.wr_valid = 1'b1;
        ovl.wr_char  = 5'd3;
        ovl.wr_last  = 1'b1;
        @(posedge clk); #1;
        ovl.clear    = 1'b0;
        ovl.wr_valid = 1'b0;
        ovl.wr_last  = 1'b0;
        for (int i = 0; i < 16; i++) mdl_buf[i] = 31;
        mdl_len = 0; mdl_widx = 0;
        check_eq("clear.disp_len", 32'(ovl.disp_len), 32'd0);
        low = 0;
        while (!ovl.wr_ready && low < 40) begin
            low++;
            @(posedge clk); #1;
        end
        check_eq("clear.ready_low_cycles", 32'(low), 32'd16);
        check_eq("clear.disp_len_after", 32'(ovl.disp_len), 32'd0);
        pixel(100, 55, "cleared_cell0");

        // blinking
        send(5, 0); send(6, 0); send(4, 1);
        check_eq("mha.disp_len", 32'(ovl.disp_len), 32'd3);
        ovl.blink_en = 1'b1;
        mdl_blink_en = 1;
        ticks(31);
        pixel(112, 55, "blink_31_ticks");
        ticks(1);
        pixel(112, 55, "blink_hidden");
        pixel(150, 55, "blink_hidden_out");
        ticks(32);
        pixel(124, 55, "blink_shown");
        ticks(40);
        ovl.blink_en = 1'b0;
        mdl_blink_en = 0;
        @(posedge clk); #1;
        mdl_cnt = 0; mdl_vis = 1;
        pixel(100, 55, "blink_off");

        // reset in the middle of a load
        send(2, 0); send(3, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        mdl_reset();
        @(posedge clk); #4;
        reset = 1'b0;
        @(posedge clk); #1;
        send(7, 1);
        check_eq("post_reset.disp_len", 32'(ovl.disp_len), 32'd1);
        pixel(100, 55, "post_reset_cell0");
        pixel(112, 55, "post_reset_cell1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
